// File: rtl/gcn_pkg.sv
// Shared widths, types and FSM encoding for the GCN aggregation datapath.
package gcn_pkg;
  localparam int DOT_PROD_WIDTH = 16;
  localparam int FM_WM_COLS     = 3;
  localparam int FM_WM_ROWS     = 6;
  localparam int NUM_OF_EDGES   = 6;
  localparam int FM_WM_WIDTH    = $clog2(FM_WM_ROWS);
  localparam int COO_ADDR_WIDTH = $clog2(NUM_OF_EDGES);

  typedef logic [DOT_PROD_WIDTH-1:0] elem_t;
  typedef elem_t [0:FM_WM_COLS-1]    row_t;
  typedef logic [FM_WM_WIDTH-1:0]    node_idx_t;
  typedef logic [COO_ADDR_WIDTH-1:0] coo_addr_t;
  typedef node_idx_t [0:1]           edge_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    EDGE_A = 3'd2,
    EDGE_B = 3'd3,
    DONE   = 3'd4
  } agg_state_t;

  localparam node_idx_t LAST_NODE = node_idx_t'(FM_WM_ROWS - 1);
  localparam coo_addr_t LAST_EDGE = coo_addr_t'(NUM_OF_EDGES - 1);

  // Node indices past the last row mark an edge that must be skipped.
  function automatic logic node_ok(input node_idx_t n);
    return n <= LAST_NODE;
  endfunction
endpackage

// File: rtl/coo_aggregate_if.sv
// Memory read ports, run handshake and result read port of the aggregation stage.
interface coo_aggregate_if;
  import gcn_pkg::*;

  logic      start;
  coo_addr_t coo_address;
  edge_t     coo_in;
  node_idx_t fm_wm_row_address;
  row_t      fm_wm_row_in;
  node_idx_t fm_wm_adj_row;
  row_t      fm_wm_adj_out;
  logic      done;

  modport master (
    output start, coo_in, fm_wm_row_in, fm_wm_adj_row,
    input  coo_address, fm_wm_row_address, fm_wm_adj_out, done
  );

  modport slave (
    input  start, coo_in, fm_wm_row_in, fm_wm_adj_row,
    output coo_address, fm_wm_row_address, fm_wm_adj_out, done
  );
endinterface

// File: rtl/aggregate_row_adder.sv
// Column-wise wrapping add of an FM*WM row onto an accumulator row; disabled passes the accumulator through.
module aggregate_row_adder
  import gcn_pkg::*;
(
  input  row_t a,
  input  row_t b,
  input  logic en,
  output row_t sum
);
  always_comb begin
    sum = a;
    if (en) begin
      for (int c = 0; c < FM_WM_COLS; c++) begin
        sum[c] = a[c] + b[c];
      end
    end
  end
endmodule

// File: rtl/coo_aggregate.sv
// Builds (A+I)*(FM*WM): seeds each node with its own row, then adds neighbour rows over the COO edge list.
//
// state  | meaning
// IDLE   | waiting for start; accumulators untouched
// INIT   | copy FM*WM row row_cnt into acc[row_cnt]
// EDGE_A | acc[dst] += row[src] for edge coo_address
// EDGE_B | acc[src] += row[dst], then advance edge or finish
// DONE   | result frozen; done asserted while start stays high
module coo_aggregate
  import gcn_pkg::*;
(
  input logic            clk,
  input logic            reset,
  coo_aggregate_if.slave bus
);
  agg_state_t state;
  node_idx_t  row_cnt;
  coo_addr_t  coo_addr_q;
  logic       done_q;
  row_t       acc [FM_WM_ROWS];

  node_idx_t  src;
  node_idx_t  dst;
  node_idx_t  target;
  logic       edge_ok;
  logic       acc_en;
  row_t       acc_cur;
  row_t       acc_sum;

  assign src             = bus.coo_in[0];
  assign dst             = bus.coo_in[1];
  assign edge_ok         = node_ok(src) && node_ok(dst);
  assign bus.coo_address = coo_addr_q;
  assign bus.done        = done_q;

  always_comb begin
    bus.fm_wm_row_address = '0;
    target                = dst;
    case (state)
      INIT:    bus.fm_wm_row_address = row_cnt;
      EDGE_A: begin
        bus.fm_wm_row_address = src;
        target                = dst;
      end
      EDGE_B: begin
        bus.fm_wm_row_address = dst;
        target                = src;
      end
      default: bus.fm_wm_row_address = '0;
    endcase
  end

  assign acc_en  = ((state == EDGE_A) || (state == EDGE_B)) && edge_ok;
  assign acc_cur = node_ok(target) ? acc[target] : '0;

  aggregate_row_adder u_adder (
    .a   (acc_cur),
    .b   (bus.fm_wm_row_in),
    .en  (acc_en),
    .sum (acc_sum)
  );

  assign bus.fm_wm_adj_out = node_ok(bus.fm_wm_adj_row) ? acc[bus.fm_wm_adj_row] : '0;

  // done lags entry into DONE by one cycle so it rises FM_WM_ROWS + 2*NUM_OF_EDGES + 1 edges after start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      row_cnt    <= '0;
      coo_addr_q <= '0;
      done_q     <= 1'b0;
      for (int r = 0; r < FM_WM_ROWS; r++) begin
        acc[r] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= INIT;
            row_cnt    <= '0;
            coo_addr_q <= '0;
          end
        end
        INIT: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            acc[row_cnt] <= bus.fm_wm_row_in;
            if (row_cnt == LAST_NODE) begin
              state <= EDGE_A;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        EDGE_A: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            if (acc_en) begin
              acc[target] <= acc_sum;
            end
            state <= EDGE_B;
          end
        end
        EDGE_B: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            if (acc_en) begin
              acc[target] <= acc_sum;
            end
            if (coo_addr_q == LAST_EDGE) begin
              state <= DONE;
            end else begin
              coo_addr_q <= coo_addr_q + 1'b1;
              state      <= EDGE_A;
            end
          end
        end
        DONE: begin
          if (!bus.start) begin
            state <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coo_aggregate.sv
// Directed bench for coo_aggregate: base graph, wrap-around, mid-run reset, start drop and done handshake.
module tb_coo_aggregate;
  import gcn_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  coo_aggregate_if bus ();

  coo_aggregate dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  edge_t coo_mem [0:7];
  row_t  fm_mem  [0:7];

  assign bus.coo_in       = coo_mem[bus.coo_address];
  assign bus.fm_wm_row_in = fm_mem[bus.fm_wm_row_address];

  typedef struct {
    node_idx_t row;
    row_t      exp;
  } rd_vec_t;

  rd_vec_t tbl [8];
  int n_vec = 0;
  int n_err = 0;
  int cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic row_t splat(input int v);
    row_t r;
    for (int c = 0; c < FM_WM_COLS; c++) r[c] = elem_t'(v);
    return r;
  endfunction

  task automatic set_edge(input int i, input int s, input int d);
    coo_mem[i][0] = node_idx_t'(s);
    coo_mem[i][1] = node_idx_t'(d);
  endtask

  task automatic load_base();
    for (int r = 0; r < 6; r++) fm_mem[r] = splat(r + 1);
    fm_mem[6] = splat(16'h1234);
    fm_mem[7] = splat(16'h4321);
    set_edge(0, 0, 1);
    set_edge(1, 0, 1);
    set_edge(2, 2, 3);
    set_edge(3, 4, 5);
    set_edge(4, 4, 4);
    set_edge(5, 6, 0);
    set_edge(6, 0, 0);
    set_edge(7, 0, 0);
  endtask

  task automatic load_wrap();
    load_base();
    fm_mem[0][0] = 16'hFFFF;
    fm_mem[0][1] = 16'h0001;
    fm_mem[0][2] = 16'h0000;
    set_edge(0, 0, 0);
    for (int i = 1; i < 6; i++) set_edge(i, 7, 7);
  endtask

  task automatic fill_base_tbl();
    int exp_v [8] = '{5, 4, 7, 7, 21, 11, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tbl[i].row = node_idx_t'(i);
      tbl[i].exp = splat(exp_v[i]);
    end
  endtask

  task automatic fill_wrap_tbl();
    for (int i = 0; i < 8; i++) begin
      tbl[i].row = node_idx_t'(i);
      tbl[i].exp = (i < 6) ? splat(i + 1) : '0;
    end
    tbl[0].exp[0] = 16'hFFFD;
    tbl[0].exp[1] = 16'h0003;
    tbl[0].exp[2] = 16'h0000;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.fm_wm_adj_row = tbl[i].row;
      #1;
      check($sformatf("%s_row%0d", tag, i), 64'(bus.fm_wm_adj_out), 64'(tbl[i].exp));
    end
  endtask

  task automatic run(output int cycles);
    bus.start = 1'b1;
    tick();
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.fm_wm_adj_row = '0;
    load_base();
    reset = 1'b0;
    tick();
    tick();
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_coo_addr", 64'(bus.coo_address), 64'(0));
    check("rst_state", 64'(dut.state), 64'(IDLE));
    check("rst_row0", 64'(bus.fm_wm_adj_out), 64'(0));
    reset = 1'b1;
    tick();

    // Base graph and done handshake
    run(cyc);
    check("base_latency", 64'(cyc), 64'(19));
    fill_base_tbl();
    check_table("base");
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_done%0d", i), 64'(bus.done), 64'(1));
    end
    bus.start = 1'b0;
    tick();
    check("drop_done", 64'(bus.done), 64'(0));
    check("drop_state", 64'(dut.state), 64'(IDLE));
    bus.fm_wm_adj_row = node_idx_t'(6);
    #1;
    check("adj_row6", 64'(bus.fm_wm_adj_out), 64'(0));

    // Wrap-around with a self edge and out-of-range edges
    load_wrap();
    tick();
    run(cyc);
    check("wrap_latency", 64'(cyc), 64'(19));
    fill_wrap_tbl();
    check_table("wrap");
    bus.start = 1'b0;
    tick();

    // Reset in EDGE_A of edge 2
    load_base();
    bus.start = 1'b1;
    tick();
    repeat (10) tick();
    check("mid_state", 64'(dut.state), 64'(EDGE_A));
    check("mid_coo_addr", 64'(bus.coo_address), 64'(2));
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    bus.start = 1'b0;
    check("mrst_done", 64'(bus.done), 64'(0));
    check("mrst_state", 64'(dut.state), 64'(IDLE));
    check("mrst_coo_addr", 64'(bus.coo_address), 64'(0));
    for (int i = 0; i < 6; i++) begin
      bus.fm_wm_adj_row = node_idx_t'(i);
      #1;
      check($sformatf("mrst_row%0d", i), 64'(bus.fm_wm_adj_out), 64'(0));
    end
    tick();

    // start dropped while INIT writes row 3, then rerun
    bus.start = 1'b1;
    tick();
    repeat (3) tick();
    check("init3_state", 64'(dut.state), 64'(INIT));
    check("init3_row", 64'(dut.row_cnt), 64'(3));
    bus.start = 1'b0;
    tick();
    check("sdrop_state", 64'(dut.state), 64'(IDLE));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sdrop_done%0d", i), 64'(bus.done), 64'(0));
      tick();
    end
    run(cyc);
    check("rerun_latency", 64'(cyc), 64'(19));
    fill_base_tbl();
    check_table("rerun");
    bus.start = 1'b0;
    tick();
    check("rerun_idle_done", 64'(bus.done), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
